// File: rtl/fat_write_scheduler.sv
// Sequences FAT sector generation (ping-pong halves) and SD sector writes.
// Optional FAT_MIRROR_EN: write every sector to both FAT copies before releasing its half.
module fat_write_scheduler #(
  parameter logic [31:0] FAT_START_LBA   = 32'd38,
  parameter logic [31:0] SECTORS_PER_FAT = 32'd4,
  parameter logic [15:0] FAT_SECTORS     = 16'd4,
  parameter logic [15:0] ACK_TIMEOUT     = 16'd1000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        START,
  output logic        GEN_ENA,
  output logic [1:0]  BUFWAITING,
  input  logic [1:0]  BUFREADY,
  output logic        WR_REQ,
  output logic [31:0] WR_LBA,
  output logic        WR_HALF,
  input  logic        WR_ACK,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR
);

`ifdef FAT_MIRROR_EN
  localparam bit MIRROR_EN = 1'b1;
`else
  localparam bit MIRROR_EN = 1'b0;
`endif

  // A run never extends past the end of one FAT copy.
  localparam logic [15:0] RUN_SECTORS =
    (FAT_SECTORS > SECTORS_PER_FAT[15:0]) ? SECTORS_PER_FAT[15:0] : FAT_SECTORS;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_WRITE, S_FINISH, S_ERR} state_t;

  state_t      state, state_nxt;
  logic        half, half_nxt;
  logic [15:0] sector, sector_nxt;
  logic        copy, copy_nxt;
  logic        gap, gap_nxt;
  logic [15:0] timer, timer_nxt;
  logic        rdy_seen, rdy_seen_nxt;
  logic        error_r, error_nxt;
  logic        gen_ena_s;

  logic [1:0]  fill_code, other_code;
  logic        last_sector;
  logic [31:0] lba;

  assign fill_code   = half ? 2'b10 : 2'b01;
  assign other_code  = half ? 2'b01 : 2'b10;
  assign last_sector = (sector == RUN_SECTORS - 16'd1);

`ifdef FAT_MIRROR_EN
  assign lba = FAT_START_LBA + {16'd0, sector} + (copy ? SECTORS_PER_FAT : 32'd0);
`else
  assign lba = FAT_START_LBA + {16'd0, sector};
`endif

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state    <= S_IDLE;
      half     <= 1'b0;
      sector   <= 16'd0;
      copy     <= 1'b0;
      gap      <= 1'b0;
      timer    <= 16'd0;
      rdy_seen <= 1'b0;
      error_r  <= 1'b0;
    end else begin
      state    <= state_nxt;
      half     <= half_nxt;
      sector   <= sector_nxt;
      copy     <= copy_nxt;
      gap      <= gap_nxt;
      timer    <= timer_nxt;
      rdy_seen <= rdy_seen_nxt;
      error_r  <= error_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    half_nxt     = half;
    sector_nxt   = sector;
    copy_nxt     = copy;
    gap_nxt      = gap;
    timer_nxt    = timer;
    rdy_seen_nxt = 1'b0;
    error_nxt    = error_r;
    gen_ena_s    = 1'b0;
    BUFWAITING   = 2'b00;
    WR_REQ       = 1'b0;
    WR_LBA       = 32'd0;
    WR_HALF      = 1'b0;
    DONE         = 1'b0;

    case (state)
      S_IDLE: begin
        if (START) begin
          state_nxt  = S_FILL;
          half_nxt   = 1'b0;
          sector_nxt = 16'd0;
          copy_nxt   = 1'b0;
          gap_nxt    = 1'b0;
          timer_nxt  = 16'd0;
          error_nxt  = 1'b0;
        end
      end

      S_FILL: begin
        gen_ena_s  = 1'b1;
        BUFWAITING = fill_code;
        // Two consecutive matching samples filter the constructor's negedge skew.
        if (BUFREADY == fill_code) begin
          if (rdy_seen) state_nxt = S_WRITE;
          else          rdy_seen_nxt = 1'b1;
        end
      end

      S_WRITE: begin
        gen_ena_s  = 1'b1;
        BUFWAITING = last_sector ? 2'b00 : other_code;
        WR_REQ     = !gap;
        WR_LBA     = lba;
        WR_HALF    = half;
        if (gap) begin
          gap_nxt = 1'b0;
        end else if (WR_ACK) begin
          timer_nxt = 16'd0;
          if (MIRROR_EN && !copy) begin
            copy_nxt = 1'b1;
            gap_nxt  = 1'b1;
          end else begin
            copy_nxt = 1'b0;
            if (last_sector) begin
              state_nxt = S_FINISH;
            end else begin
              sector_nxt = sector + 16'd1;
              half_nxt   = !half;
              state_nxt  = S_FILL;
            end
          end
        end else if (timer == ACK_TIMEOUT - 16'd1) begin
          // This cycle is the ACK_TIMEOUT-th with WR_REQ high.
          timer_nxt = 16'd0;
          error_nxt = 1'b1;
          state_nxt = S_ERR;
        end else begin
          timer_nxt = timer + 16'd1;
        end
      end

      S_FINISH: begin
        DONE      = 1'b1;
        state_nxt = S_IDLE;
      end

      S_ERR: begin
        state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // Reset drops the constructor enable immediately, not one edge later.
  assign GEN_ENA = gen_ena_s & RESET_N;
  assign BUSY    = (state != S_IDLE);
  assign ERROR   = error_r;

endmodule

// File: tb/tb_fat_write_scheduler.sv
// Bench for fat_write_scheduler: constructor and SD-engine responders plus a write-sequence model.
module tb_fat_write_scheduler;
  localparam logic [31:0] START_LBA = 32'd100;
  localparam logic [31:0] SPF       = 32'd4;
  localparam int          NSEC      = 4;
  localparam logic [15:0] TMO       = 16'd16;
`ifdef FAT_MIRROR_EN
  localparam int NCOPY = 2;
`else
  localparam int NCOPY = 1;
`endif

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        START = 1'b0;
  logic        GEN_ENA;
  logic [1:0]  BUFWAITING;
  logic [1:0]  BUFREADY;
  logic        WR_REQ;
  logic [31:0] WR_LBA;
  logic        WR_HALF;
  logic        WR_ACK;
  logic        BUSY;
  logic        DONE;
  logic        ERROR;

  fat_write_scheduler #(
    .FAT_START_LBA  (START_LBA),
    .SECTORS_PER_FAT(SPF),
    .FAT_SECTORS    (16'(NSEC)),
    .ACK_TIMEOUT    (TMO)
  ) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .START     (START),
    .GEN_ENA   (GEN_ENA),
    .BUFWAITING(BUFWAITING),
    .BUFREADY  (BUFREADY),
    .WR_REQ    (WR_REQ),
    .WR_LBA    (WR_LBA),
    .WR_HALF   (WR_HALF),
    .WR_ACK    (WR_ACK),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ERROR     (ERROR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] lba;
    logic        half;
    logic [1:0]  bw;
  } wr_t;

  wr_t exp_q[$];
  int  done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected writes of one full run: sector s lives in half s%2, copy c at LBA + c*SPF,
  // and the other half is prefetched unless s is the last sector.
  function automatic void expect_run();
    wr_t w;
    for (int s = 0; s < NSEC; s++) begin
      for (int c = 0; c < NCOPY; c++) begin
        w.lba  = START_LBA + 32'(s) + 32'(c) * SPF;
        w.half = s[0];
        w.bw   = (s + 1 < NSEC) ? (s[0] ? 2'b01 : 2'b10) : 2'b00;
        exp_q.push_back(w);
      end
    end
  endfunction

  // Constructor: fills the requested half after 6 cycles; reports 10 while disabled.
  logic       auto_fill = 1'b1;
  logic [1:0] force_val = 2'b00;
  initial begin
    int fill_cnt;
    fill_cnt = 0;
    BUFREADY = 2'b10;
    forever begin
      @(negedge CLK);
      if (!auto_fill) begin
        BUFREADY = force_val;
        fill_cnt = 0;
      end else if (!GEN_ENA) begin
        BUFREADY = 2'b10;
        fill_cnt = 0;
      end else if (BUFWAITING != 2'b00 && BUFWAITING != BUFREADY) begin
        fill_cnt++;
        if (fill_cnt >= 6) begin
          BUFREADY = BUFWAITING;
          fill_cnt = 0;
        end
      end
    end
  end

  // SD engine: acknowledges 5 cycles after WR_REQ rises.
  logic ack_en = 1'b1;
  initial begin
    int req_age;
    req_age = 0;
    WR_ACK = 1'b0;
    forever begin
      @(negedge CLK);
      WR_ACK = 1'b0;
      if (WR_REQ && ack_en) begin
        req_age++;
        if (req_age == 5) WR_ACK = 1'b1;
      end else begin
        req_age = 0;
      end
    end
  end

  // Per-cycle comparison against the expected write sequence.
  initial begin
    logic prev_req;
    wr_t  cur;
    prev_req = 1'b0;
    cur.lba = 32'd0; cur.half = 1'b0; cur.bw = 2'b00;
    forever begin
      @(negedge CLK);
      if (DONE === 1'b1) done_cnt++;
      if (WR_REQ === 1'b1 && !prev_req) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got lba %0d half %0d, want no write", WR_LBA, WR_HALF);
        end else begin
          cur = exp_q.pop_front();
          check("wr_half", 64'(WR_HALF), 64'(cur.half));
        end
      end
      if (WR_REQ === 1'b1) begin
        check("wr_lba", 64'(WR_LBA), 64'(cur.lba));
        check("bufwaiting_in_write", 64'(BUFWAITING), 64'(cur.bw));
      end
      if (BUSY === 1'b0)
        check("idle_outputs", 64'({GEN_ENA, WR_REQ, BUFWAITING, DONE}), 64'd0);
      prev_req = (WR_REQ === 1'b1);
    end
  end

  task automatic pulse_start();
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge CLK);
      seen = (DONE === 1'b1);
    end
    check(name, 64'(seen), 64'd1);
  endtask

  initial begin
    int  d0;
    wr_t first;
    bit  seen;
    int  rises;
    bit  p;

    // Reset state
    repeat (3) @(negedge CLK);
    check("reset_outputs",
          64'({GEN_ENA, BUFWAITING, WR_REQ, WR_LBA, WR_HALF, BUSY, DONE, ERROR}), 64'd0);
    RESET_N = 1'b1;
    @(negedge CLK);
    check("idle_busy", 64'(BUSY), 64'd0);

    // Pin the model with hand-computed values
    expect_run();
    check("model_size", 64'(exp_q.size()), 64'(4 * NCOPY));
    check("model_lba0", 64'(exp_q[0].lba), 64'd100);
    check("model_bw0", 64'(exp_q[0].bw), 64'b10);
    check("model_bw_last", 64'(exp_q[exp_q.size() - 1].bw), 64'b00);
`ifdef FAT_MIRROR_EN
    check("model_lba1", 64'(exp_q[1].lba), 64'd104);
    check("model_lba7", 64'(exp_q[7].lba), 64'd107);
    check("model_half2", 64'(exp_q[2].half), 64'd1);
`else
    check("model_lba1", 64'(exp_q[1].lba), 64'd101);
    check("model_lba3", 64'(exp_q[3].lba), 64'd103);
    check("model_half1", 64'(exp_q[1].half), 64'd1);
`endif

    // Full run
    d0 = done_cnt;
    pulse_start();
    check("first_request_lower", 64'(BUFWAITING), 64'b01);
    check("gen_ena_run", 64'(GEN_ENA), 64'd1);
    wait_done("run1_done");
    @(negedge CLK);
    check("run1_done_count", 64'(done_cnt - d0), 64'd1);
    check("run1_error", 64'(ERROR), 64'd0);
    check("run1_all_written", 64'(exp_q.size()), 64'd0);

    // Ack timeout
    ack_en = 1'b0;
    expect_run();
    first = exp_q[0];
    exp_q.delete();
    exp_q.push_back(first);
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge CLK);
      seen = (WR_REQ === 1'b1);
    end
    check("tmo_req_rose", 64'(seen), 64'd1);
    repeat (15) @(negedge CLK);
    check("tmo_req_held", 64'(WR_REQ), 64'd1);
    check("tmo_no_error_yet", 64'(ERROR), 64'd0);
    @(negedge CLK);
    check("tmo_req_dropped", 64'(WR_REQ), 64'd0);
    check("tmo_error_set", 64'(ERROR), 64'd1);
    check("tmo_gen_ena", 64'(GEN_ENA), 64'd0);
    @(negedge CLK);
    check("tmo_busy", 64'(BUSY), 64'd0);
    check("tmo_error_sticky", 64'(ERROR), 64'd1);
    ack_en = 1'b1;
    expect_run();
    pulse_start();
    check("start_clears_error", 64'(ERROR), 64'd0);
    wait_done("run2_done");
    @(negedge CLK);

    // Reset during the second write
    exp_q.delete();
    expect_run();
    pulse_start();
    rises = 0;
    p = 1'b0;
    for (int i = 0; i < 2000 && rises < 2; i++) begin
      @(negedge CLK);
      if (WR_REQ === 1'b1 && !p) rises++;
      p = (WR_REQ === 1'b1);
    end
    check("rst_second_write_seen", 64'(rises), 64'd2);
    RESET_N = 1'b0;
    #1;
    check("rst_gen_ena_same_cycle", 64'(GEN_ENA), 64'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    check("rst_outputs",
          64'({GEN_ENA, BUFWAITING, WR_REQ, WR_LBA, WR_HALF, BUSY, DONE, ERROR}), 64'd0);
    exp_q.delete();
    expect_run();
    pulse_start();
    wait_done("run3_done");
    @(negedge CLK);
    check("run3_all_written", 64'(exp_q.size()), 64'd0);

    // START while busy is ignored
    expect_run();
    d0 = done_cnt;
    pulse_start();
    repeat (8) @(negedge CLK);
    check("busy_mid_run", 64'(BUSY), 64'd1);
    pulse_start();
    repeat (8) @(negedge CLK);
    pulse_start();
    wait_done("run4_done");
    repeat (3) @(negedge CLK);
    check("run4_done_count", 64'(done_cnt - d0), 64'd1);
    check("run4_all_written", 64'(exp_q.size()), 64'd0);
    check("run4_idle", 64'(BUSY), 64'd0);

    // Fill filter: one-cycle BUFREADY blip versus a two-cycle hold
    expect_run();
    auto_fill = 1'b0;
    force_val = 2'b00;
    pulse_start();
    repeat (3) @(negedge CLK);
    @(posedge CLK);
    #2 force_val = 2'b01;
    @(posedge CLK);
    #2 force_val = 2'b00;
    repeat (4) @(negedge CLK);
    check("blip_no_req", 64'(WR_REQ), 64'd0);
    check("blip_still_fill", 64'(BUFWAITING), 64'b01);
    @(posedge CLK);
    #2 force_val = 2'b01;
    @(negedge CLK);
    @(negedge CLK);
    check("hold_one_no_req", 64'(WR_REQ), 64'd0);
    @(negedge CLK);
    check("hold_two_req", 64'(WR_REQ), 64'd1);
    auto_fill = 1'b1;
    wait_done("run5_done");
    @(negedge CLK);
    check("run5_all_written", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, want finish before %0t", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule
